// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port, write-first 32-bit word RAM.
// Round-robin with a bounded burst hold. Read data returns one cycle later, tagged one-hot to its issuer.
module ram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [31:0]       req_addr0,
    input  logic [31:0]       req_addr1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic       last;
    logic [3:0] burst;
    logic [1:0] rsp_owner;
    logic [1:0] grant;
    logic       fire;
    logic       sel;

    // The RAM is word-addressed and narrower than the request bus, so the upper address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr0[31:ADDR_W], req_addr1[31:ADDR_W]};

    // NOTE: every combinational output gets a default first, so no path through the case infers a latch.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (burst < BURST_MAX) grant = last ? 2'b10 : 2'b01;
                else                   grant = last ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant;
    assign fire      = |grant;
    assign sel       = grant[1];

    // Port 0's address is the idle default, so ram_addr needs no separate idle mux leg.
    always_comb begin
        ram_addr  = req_addr0[ADDR_W-1:0];
        ram_wdata = 32'h0;
        ram_we    = 1'b0;
        if (grant[1]) begin
            ram_addr  = req_addr1[ADDR_W-1:0];
            ram_wdata = req_wdata1;
            ram_we    = req_we[1];
        end else if (grant[0]) begin
            ram_wdata = req_wdata0;
            ram_we    = req_we[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register here samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            burst     <= 4'd0;
            rsp_owner <= 2'b00;
        end else begin
            rsp_owner <= grant;
            if (fire) begin
                if (sel == last) begin
                    burst <= (burst >= BURST_MAX) ? BURST_MAX : burst + 4'd1;
                end else begin
                    last  <= sel;
                    burst <= 4'd1;
                end
            end else begin
                burst <= 4'd0;
            end
        end
    end

    assign rsp_valid = rsp_owner;
    assign rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: two instances (MAX_BURST 4 and 1), each on its own write-first RAM model.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instance A: MAX_BURST = 4
    logic [1:0]  valid, we, ready, rsp;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata, ram_wdata, ram_rdata;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] mem_a [0:1023];

    ram_port_arbiter #(.ADDR_W(10), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(valid), .req_ready(ready), .req_we(we),
        .req_addr0(addr0), .req_addr1(addr1), .req_wdata0(wdata0), .req_wdata1(wdata1),
        .rsp_valid(rsp), .rsp_rdata(rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            mem_a[ram_addr] <= ram_wdata;
            ram_rdata       <= ram_wdata;
        end else begin
            ram_rdata <= mem_a[ram_addr];
        end
    end

    // Instance B: MAX_BURST = 1
    logic [1:0]  b_valid, b_we, b_ready, b_rsp;
    logic [31:0] b_addr0, b_addr1, b_wdata0, b_wdata1, b_rdata, b_ram_wdata, b_ram_rdata;
    logic [9:0]  b_ram_addr;
    logic        b_ram_we;
    logic [31:0] mem_b [0:1023];

    ram_port_arbiter #(.ADDR_W(10), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr0(b_addr0), .req_addr1(b_addr1), .req_wdata0(b_wdata0), .req_wdata1(b_wdata1),
        .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we), .ram_rdata(b_ram_rdata)
    );

    always @(posedge clk) begin
        if (b_ram_we) begin
            mem_b[b_ram_addr] <= b_ram_wdata;
            b_ram_rdata       <= b_ram_wdata;
        end else begin
            b_ram_rdata <= mem_b[b_ram_addr];
        end
    end

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  e_ready;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_rsp;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        valid = v; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g, prev_g;
        logic [1:0] bb_valid [9];
        logic [1:0] bb_ready [9];

        vecs[0] = '{2'b01, 2'b01, 32'h5, 32'h0, 32'hDEADBEEF, 32'h0,
                    2'b01, 1'b1, 10'h005, 32'hDEADBEEF, 2'b01, 32'hDEADBEEF};
        vecs[1] = '{2'b01, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0,
                    2'b01, 1'b0, 10'h005, 32'h0, 2'b01, 32'hDEADBEEF};
        vecs[2] = '{2'b10, 2'b00, 32'h0, 32'h0000_0405, 32'h0, 32'h0,
                    2'b10, 1'b0, 10'h005, 32'h0, 2'b10, 32'hDEADBEEF};
        vecs[3] = '{2'b00, 2'b00, 32'h3, 32'h9, 32'h0, 32'h0,
                    2'b00, 1'b0, 10'h003, 32'h0, 2'b00, 32'h0};
        vecs[4] = '{2'b10, 2'b10, 32'h20, 32'h9, 32'h0, 32'h12345678,
                    2'b10, 1'b1, 10'h009, 32'h12345678, 2'b10, 32'h12345678};

        drive(2'b00, 2'b00, 0, 0, 0, 0);
        b_valid = 2'b00; b_we = 2'b00; b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;

        // Reset, then idle for 10 cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rsp_valid", 32'(rsp), 32'h0);
            check("idle_req_ready", 32'(ready), 32'h0);
            check("idle_ram_we", 32'(ram_we), 32'h0);
        end

        // Single-port traffic, address truncation, idle defaults
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
            @(posedge clk); #1;
            check($sformatf("vec%0d_rsp_valid", i), 32'(rsp), 32'(vecs[i].e_rsp));
            if (vecs[i].e_rsp != 2'b00)
                check($sformatf("vec%0d_rsp_rdata", i), rdata, vecs[i].e_rdata);
        end

        // Reset in the middle of a pending response drops rsp_valid without a clock
        @(negedge clk);
        drive(2'b01, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("pre_reset_rsp_valid", 32'(rsp), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_rsp_valid", 32'(rsp), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous contention with MAX_BURST=4: p1 x4, p0 x4, p1 x4, p0 x4
        prev_g = 2'b00;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 32'h5, 32'h9, 32'h0, 32'h0);
            exp_g = (((k / 4) % 2) == 0) ? 2'b10 : 2'b01;
            #1;
            check($sformatf("contend%0d_ready", k), 32'(ready), 32'(exp_g));
            if (k > 0) begin
                check($sformatf("contend%0d_rsp_valid", k), 32'(rsp), 32'(prev_g));
                check($sformatf("contend%0d_rsp_rdata", k), rdata,
                      (prev_g == 2'b01) ? 32'hDEADBEEF : 32'h12345678);
            end
            prev_g = exp_g;
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        #1;
        check("contend_last_rsp_valid", 32'(rsp), 32'(prev_g));

        // Write collision on the MAX_BURST=1 instance: p1 first (last=1 after reset), then p0
        @(negedge clk);
        b_valid = 2'b11; b_we = 2'b11; b_addr0 = 32'h7; b_addr1 = 32'h7;
        b_wdata0 = 32'h11; b_wdata1 = 32'h22;
        #1;
        check("coll_first_ready", 32'(b_ready), 32'h2);
        check("coll_first_wdata", b_ram_wdata, 32'h22);
        @(negedge clk);
        b_valid = 2'b01; b_we = 2'b01;
        #1;
        check("coll_second_ready", 32'(b_ready), 32'h1);
        check("coll_second_rsp", 32'(b_rsp), 32'h2);
        @(negedge clk);
        b_valid = 2'b10; b_we = 2'b00; b_addr1 = 32'h7; b_wdata1 = 32'h0;
        #1;
        check("coll_read_ready", 32'(b_ready), 32'h2);
        check("coll_second_rsp_done", 32'(b_rsp), 32'h1);
        @(negedge clk);
        b_valid = 2'b00;
        #1;
        check("coll_read_rsp", 32'(b_rsp), 32'h2);
        check("coll_read_data", b_rdata, 32'h11);

        // Strict alternation on the MAX_BURST=1 instance
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_valid = 2'b11; b_we = 2'b00;
            #1;
            // the previous cycle was an idle, so burst is 0 and last=1 holds once
            check($sformatf("alt%0d_ready", k), 32'(b_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
        end
        @(negedge clk);
        b_valid = 2'b00;

        // Burst break: p0 x3, gap, then p0 holds 4 fresh beats before p1 is served
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bb_valid = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        bb_ready = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(bb_valid[k], 2'b00, 32'h5, 32'h9, 32'h0, 32'h0);
            #1;
            check($sformatf("break%0d_ready", k), 32'(ready), 32'(bb_ready[k]));
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        #1;
        check("break_final_rsp", 32'(rsp), 32'h2);
        check("break_final_rdata", rdata, 32'h12345678);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
